// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the IF/MEM stages, the unified memory port and the
// pipeline stall controls of the memory port arbiter.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        port_req;
  logic        port_we;
  logic [31:0] port_addr;
  logic [31:0] port_wdata;
  logic        port_ack;
  logic [31:0] port_rdata;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic [31:0] mem_rdata;
  logic        mem_valid;
  logic        PCWrite;
  logic        IF_ID_Write;
  logic        IF_ID_Bubble;
  logic        Pipe_hold;
  logic        bus_err;

  // Arbiter side: owns the memory port and the stall controls.
  modport master (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata,
    input  port_ack, port_rdata,
    output port_req, port_we, port_addr, port_wdata,
    output if_rdata, if_valid, mem_rdata, mem_valid,
    output PCWrite, IF_ID_Write, IF_ID_Bubble, Pipe_hold, bus_err
  );

  // Pipeline/memory side.
  modport slave (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata,
    output port_ack, port_rdata,
    input  port_req, port_we, port_addr, port_wdata,
    input  if_rdata, if_valid, mem_rdata, mem_valid,
    input  PCWrite, IF_ID_Write, IF_ID_Bubble, Pipe_hold, bus_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported instruction/data memory between the IF and MEM
// stages, drives the pipeline freeze/bubble controls and watches for a hung memory.
module mem_port_arbiter #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.master  bus
);

  localparam int unsigned     CNT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, FETCH, DATA, ERR} state_t;

  state_t             state_q, state_d;
  logic               port_req_q, port_req_d;
  logic               port_we_q, port_we_d;
  logic [31:0]        port_addr_q, port_addr_d;
  logic [31:0]        port_wdata_q, port_wdata_d;
  logic [31:0]        if_rdata_q, if_rdata_d;
  logic [31:0]        mem_rdata_q, mem_rdata_d;
  logic               if_valid_q, if_valid_d;
  logic               mem_valid_q, mem_valid_d;
  logic               bus_err_q, bus_err_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]   wait_inc;
  logic               fstall, dstall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      port_req_q   <= 1'b0;
      port_we_q    <= 1'b0;
      port_addr_q  <= '0;
      port_wdata_q <= '0;
      if_rdata_q   <= '0;
      mem_rdata_q  <= '0;
      if_valid_q   <= 1'b0;
      mem_valid_q  <= 1'b0;
      bus_err_q    <= 1'b0;
      wait_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      port_req_q   <= port_req_d;
      port_we_q    <= port_we_d;
      port_addr_q  <= port_addr_d;
      port_wdata_q <= port_wdata_d;
      if_rdata_q   <= if_rdata_d;
      mem_rdata_q  <= mem_rdata_d;
      if_valid_q   <= if_valid_d;
      mem_valid_q  <= mem_valid_d;
      bus_err_q    <= bus_err_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

  assign wait_inc = wait_cnt_q + CNT_ONE;

  always_comb begin
    state_d      = state_q;
    port_req_d   = port_req_q;
    port_we_d    = port_we_q;
    port_addr_d  = port_addr_q;
    port_wdata_d = port_wdata_q;
    if_rdata_d   = if_rdata_q;
    mem_rdata_d  = mem_rdata_q;
    if_valid_d   = 1'b0;
    mem_valid_d  = 1'b0;
    bus_err_d    = bus_err_q;
    wait_cnt_d   = wait_cnt_q;

    case (state_q)
      IDLE: begin
        // A requester still seeing its valid pulse has already been served.
        if (bus.mem_req && !mem_valid_q) begin
          state_d      = DATA;
          port_req_d   = 1'b1;
          port_we_d    = bus.mem_we;
          port_addr_d  = bus.mem_addr;
          port_wdata_d = bus.mem_wdata;
          wait_cnt_d   = '0;
        end else if (bus.if_req && !if_valid_q) begin
          state_d      = FETCH;
          port_req_d   = 1'b1;
          port_we_d    = 1'b0;
          port_addr_d  = bus.if_addr;
          port_wdata_d = '0;
          wait_cnt_d   = '0;
        end
      end
      FETCH, DATA: begin
        if (bus.port_ack) begin
          state_d    = IDLE;
          port_req_d = 1'b0;
          if (state_q == FETCH) begin
            if_rdata_d = bus.port_rdata;
            if_valid_d = 1'b1;
          end else begin
            if (!port_we_q) mem_rdata_d = bus.port_rdata;
            mem_valid_d = 1'b1;
          end
        end else if (wait_inc == CNT_MAX) begin
          state_d    = ERR;
          port_req_d = 1'b0;
          bus_err_d  = 1'b1;
          wait_cnt_d = CNT_MAX;
        end else begin
          wait_cnt_d = wait_inc;
        end
      end
      ERR: begin
        port_req_d = 1'b0;
        bus_err_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Stall controls follow req/valid combinationally so the pipeline reacts in-cycle.
  assign fstall = bus.if_req & ~if_valid_q;
  assign dstall = bus.mem_req & ~mem_valid_q;

  assign bus.PCWrite      = ~(fstall | dstall | bus_err_q);
  assign bus.IF_ID_Write  = ~(fstall | dstall | bus_err_q);
  assign bus.Pipe_hold    = dstall | bus_err_q;
  assign bus.IF_ID_Bubble = fstall & ~dstall & ~bus_err_q;

  assign bus.port_req   = port_req_q;
  assign bus.port_we    = port_we_q;
  assign bus.port_addr  = port_addr_q;
  assign bus.port_wdata = port_wdata_q;
  assign bus.if_rdata   = if_rdata_q;
  assign bus.if_valid   = if_valid_q;
  assign bus.mem_rdata  = mem_rdata_q;
  assign bus.mem_valid  = mem_valid_q;
  assign bus.bus_err    = bus_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a memory responder with programmable
// latency, a scoreboard of expected completions and in-line control checks.
module tb_mem_port_arbiter;

  localparam logic [31:0] MAGIC = 32'h2048_0005;

  logic clk;
  logic reset;
  mem_port_arbiter_if bus();

  mem_port_arbiter #(.MAX_WAIT(15)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic        is_mem;
    logic [31:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   mem_lat = 2;
  bit   force_ack = 1'b0;
  int   last_len = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input bit is_mem, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(is_mem ? bus.mem_valid : bus.if_valid) && n < budget);
    if (!(is_mem ? bus.mem_valid : bus.if_valid)) begin
      checks++;
      errors++;
      $display("FAIL timeout_%s: got no valid expected valid within %0d cycles",
               is_mem ? "mem" : "if", budget);
    end
  endtask

  // Memory responder: acks mem_lat cycles after port_req rises (0 = never).
  initial begin
    int          cnt;
    logic [31:0] addr0;
    cnt = 0;
    addr0 = '0;
    bus.port_ack = 1'b0;
    bus.port_rdata = 32'hBAD0_BAD0;
    forever begin
      @(negedge clk);
      bus.port_ack = force_ack;
      bus.port_rdata = 32'hBAD0_BAD0;
      if (bus.port_req) begin
        cnt++;
        if (cnt == 1) addr0 = bus.port_addr;
        else chk("port_addr_stable", bus.port_addr, addr0);
        if (mem_lat != 0 && cnt == mem_lat) begin
          bus.port_ack = 1'b1;
          bus.port_rdata = bus.port_addr ^ MAGIC;
          last_len = cnt;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Scoreboard monitor: every valid pulse must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.if_valid || bus.mem_valid) begin
        if (bus.if_valid && bus.mem_valid) begin
          checks++;
          errors++;
          $display("FAIL dual_valid: got both valids expected one");
        end else if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got if_valid=%0b mem_valid=%0b expected none",
                   bus.if_valid, bus.mem_valid);
        end else begin
          e = sb_q.pop_front();
          chk("sb_kind", {31'd0, bus.mem_valid}, {31'd0, e.is_mem});
          chk("sb_rdata", e.is_mem ? bus.mem_rdata : bus.if_rdata, e.data);
        end
      end
    end
  end

  initial begin
    reset = 1'b0;
    bus.if_req = 1'b0;
    bus.if_addr = '0;
    bus.mem_req = 1'b0;
    bus.mem_we = 1'b0;
    bus.mem_addr = '0;
    bus.mem_wdata = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_port_req", bus.port_req, 1'b0);
    chk("rst_port_addr", bus.port_addr, 32'h0);
    chk("rst_bus_err", bus.bus_err, 1'b0);
    chk("rst_PCWrite", bus.PCWrite, 1'b1);
    chk("rst_IF_ID_Write", bus.IF_ID_Write, 1'b1);
    chk("rst_Pipe_hold", bus.Pipe_hold, 1'b0);
    chk("rst_Bubble", bus.IF_ID_Bubble, 1'b0);
    chk("rst_rdata", bus.if_rdata | bus.mem_rdata, 32'h0);
    step();
    reset = 1'b1;

    // Fetch only, L=2
    mem_lat = 2;
    step();
    bus.if_req = 1'b1;
    bus.if_addr = 32'h0040_0000;
    sb_q.push_back('{is_mem: 1'b0, data: 32'h2008_0005});
    @(negedge clk);
    chk("f_PCWrite_stall", bus.PCWrite, 1'b0);
    chk("f_Bubble", bus.IF_ID_Bubble, 1'b1);
    wait_valid(1'b0, 10);
    chk("f_PCWrite_valid", bus.PCWrite, 1'b1);
    chk("f_req_len", last_len, 2);
    step();
    bus.if_req = 1'b0;

    // Fetch and load together: data first
    step();
    bus.if_req = 1'b1;
    bus.if_addr = 32'h0040_0004;
    bus.mem_req = 1'b1;
    bus.mem_we = 1'b0;
    bus.mem_addr = 32'h1000_0010;
    sb_q.push_back('{is_mem: 1'b1, data: 32'h3048_0015});
    sb_q.push_back('{is_mem: 1'b0, data: 32'h2008_0001});
    @(negedge clk);
    chk("c_Pipe_hold", bus.Pipe_hold, 1'b1);
    chk("c_Bubble", bus.IF_ID_Bubble, 1'b0);
    chk("c_PCWrite", bus.PCWrite, 1'b0);
    @(negedge clk);
    chk("c_grant_addr", bus.port_addr, 32'h1000_0010);
    chk("c_grant_we", bus.port_we, 1'b0);
    wait_valid(1'b1, 10);
    chk("c_valid_hold", bus.Pipe_hold, 1'b0);
    chk("c_valid_bubble", bus.IF_ID_Bubble, 1'b1);
    step();
    bus.mem_req = 1'b0;
    @(negedge clk);
    chk("c_fetch_req", bus.port_req, 1'b1);
    chk("c_fetch_addr", bus.port_addr, 32'h0040_0004);
    wait_valid(1'b0, 10);
    step();
    bus.if_req = 1'b0;

    // Load arrives two cycles into a fetch
    mem_lat = 4;
    step();
    bus.if_req = 1'b1;
    bus.if_addr = 32'h0040_0008;
    sb_q.push_back('{is_mem: 1'b0, data: 32'h2008_000D});
    step();
    step();
    bus.mem_req = 1'b1;
    bus.mem_addr = 32'h1000_0014;
    sb_q.push_back('{is_mem: 1'b1, data: 32'h3048_0011});
    @(negedge clk);
    chk("p_addr_kept", bus.port_addr, 32'h0040_0008);
    chk("p_Pipe_hold", bus.Pipe_hold, 1'b1);
    wait_valid(1'b0, 10);
    step();
    bus.if_req = 1'b0;
    @(negedge clk);
    chk("p_data_addr", bus.port_addr, 32'h1000_0014);
    wait_valid(1'b1, 10);
    step();
    bus.mem_req = 1'b0;

    // Store, L=1: mem_rdata keeps the previous load value
    mem_lat = 1;
    step();
    bus.mem_req = 1'b1;
    bus.mem_we = 1'b1;
    bus.mem_addr = 32'h1000_0020;
    bus.mem_wdata = 32'hDEAD_BEEF;
    sb_q.push_back('{is_mem: 1'b1, data: 32'h3048_0011});
    @(negedge clk);
    @(negedge clk);
    chk("s_port_we", bus.port_we, 1'b1);
    chk("s_port_addr", bus.port_addr, 32'h1000_0020);
    chk("s_port_wdata", bus.port_wdata, 32'hDEAD_BEEF);
    wait_valid(1'b1, 5);
    chk("s_req_len", last_len, 1);
    step();
    bus.mem_req = 1'b0;
    bus.mem_we = 1'b0;

    // Ack exactly at cycle 15 succeeds
    mem_lat = 15;
    step();
    bus.if_req = 1'b1;
    bus.if_addr = 32'h0040_000C;
    sb_q.push_back('{is_mem: 1'b0, data: 32'h2008_0009});
    wait_valid(1'b0, 25);
    chk("w15_bus_err", bus.bus_err, 1'b0);
    chk("w15_req_len", last_len, 15);
    step();
    bus.if_req = 1'b0;

    // No ack: error after cycle 15
    mem_lat = 0;
    step();
    bus.if_req = 1'b1;
    bus.if_addr = 32'h0040_0010;
    @(posedge clk);
    repeat (15) @(negedge clk);
    chk("h_req_c15", bus.port_req, 1'b1);
    chk("h_err_c15", bus.bus_err, 1'b0);
    @(negedge clk);
    chk("h_bus_err", bus.bus_err, 1'b1);
    chk("h_port_req", bus.port_req, 1'b0);
    chk("h_PCWrite", bus.PCWrite, 1'b0);
    chk("h_Pipe_hold", bus.Pipe_hold, 1'b1);
    step();
    force_ack = 1'b1;
    step();
    force_ack = 1'b0;
    step();
    step();
    @(negedge clk);
    chk("h_late_ack_err", bus.bus_err, 1'b1);
    chk("h_late_ack_req", bus.port_req, 1'b0);
    step();
    reset = 1'b0;
    #1;
    chk("h_reset_clears", bus.bus_err, 1'b0);
    bus.if_req = 1'b0;
    step();
    reset = 1'b1;

    // Reset in the middle of a load
    mem_lat = 5;
    step();
    bus.mem_req = 1'b1;
    bus.mem_addr = 32'h1000_0018;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("r_req_before", bus.port_req, 1'b1);
    reset = 1'b0;
    #1;
    chk("r_port_req", bus.port_req, 1'b0);
    chk("r_port_addr", bus.port_addr, 32'h0);
    chk("r_mem_rdata", bus.mem_rdata, 32'h0);
    bus.mem_req = 1'b0;
    step();
    step();
    reset = 1'b1;
    mem_lat = 3;
    step();
    bus.if_req = 1'b1;
    bus.if_addr = 32'h0040_0014;
    sb_q.push_back('{is_mem: 1'b0, data: 32'h2008_0011});
    wait_valid(1'b0, 10);
    step();
    bus.if_req = 1'b0;
    repeat (4) step();
    chk("sb_drained", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequential arbiter that shares one single-ported unified instruction/data memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the 5-stage MIPS pipeline. It runs a request/acknowledge handshake with the memory, which may take several cycles to respond. While an access is outstanding it generates the pipeline freeze and bubble controls that go beside the load-use hazard unit's PCWrite/IF_ID_Write. A watchdog detects a hung memory and latches a sticky error.

## Interface
- MAX_WAIT, 15: maximum cycles an access may wait for port_ack before the error trips; legal range 1..255.
- clk  in  1  pipeline clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; IF holds it high with a stable if_addr until if_valid.
- if_addr  in  32  fetch address.
- mem_req  in  1  data request; MEM holds it high with stable mem_we/mem_addr/mem_wdata until mem_valid.
- mem_we  in  1  1 = store, 0 = load.
- mem_addr  in  32  data address.
- mem_wdata  in  32  store data.
- port_req  out  1  memory request.
- port_we  out  1  memory write enable.
- port_addr  out  32  memory address.
- port_wdata  out  32  memory write data.
- port_ack  in  1  memory completion, single-cycle pulse.
- port_rdata  in  32  read data, valid when port_ack is high.
- if_rdata  out  32  captured instruction.
- if_valid  out  1  one-cycle pulse: fetch complete.
- mem_rdata  out  32  captured load data.
- mem_valid  out  1  one-cycle pulse: data access complete. Also pulses for stores.
- PCWrite  out  1  PC update enable.
- IF_ID_Write  out  1  IF/ID register load enable.
- IF_ID_Bubble  out  1  load a NOP into IF/ID.
- Pipe_hold  out  1  freeze ID/EX, EX/MEM and MEM/WB.
- bus_err  out  1  sticky watchdog error.

## Operation
- FSM states: IDLE, FETCH, DATA, ERR.
- IDLE, arbitration:
  - A requester whose valid output is high in the current cycle is ignored.
  - Otherwise mem_req has priority over if_req, because the data access belongs to the older instruction.
  - On a grant, register port_addr/port_we/port_wdata from the winner, set port_req=1, clear wait_cnt, and go to FETCH or DATA.
- FETCH/DATA:
  - port_req and the port_* fields stay constant until port_ack.
  - An access in progress is never aborted or preempted. A mem_req that arrives during FETCH waits.
- On port_ack:
  - Capture port_rdata into if_rdata (FETCH) or mem_rdata (DATA). Stores leave mem_rdata unchanged.
  - Drop port_req, pulse the matching valid for one cycle, and return to IDLE.
  - The minimum gap between grants is therefore one cycle.
- Watchdog:
  - wait_cnt is $clog2(MAX_WAIT+1) bits wide and increments each FETCH/DATA cycle without port_ack. It saturates and never wraps.
  - When wait_cnt == MAX_WAIT with no ack, go to ERR: port_req=0, bus_err=1.
  - ERR is left only by reset.
  - A port_ack in the same cycle the count reaches MAX_WAIT counts as success, not error.
- port_ack seen in IDLE or ERR is ignored.
- Stall outputs are combinational:
  - fstall = if_req & ~if_valid.
  - dstall = mem_req & ~mem_valid.
  - PCWrite = IF_ID_Write = ~(fstall | dstall | bus_err).
  - Pipe_hold = dstall | bus_err.
  - IF_ID_Bubble = fstall & ~dstall & ~bus_err.
- Reset values: state IDLE, port_req/port_we 0, port_addr/port_wdata/if_rdata/mem_rdata 0, valids 0, bus_err 0, wait_cnt 0. With no requests active: PCWrite=IF_ID_Write=1, Pipe_hold=IF_ID_Bubble=0.
- Reset asserted mid-access drops port_req immediately (asynchronous) and discards the access. No valid is issued for it.

## Timing
- Grant: the request is sampled at edge N and port_req is high after edge N.
- Memory acks L cycles after port_req rises (L ≥ 1): the valid is high in the cycle after the ack edge.
- Total latency from request to valid is L+2 cycles for an uncontended access.
- Back-to-back, data then fetch, both pending: DATA grant, ack, one IDLE/valid cycle in which the fetch is granted, then FETCH.
- The stall outputs react in the same cycle as req/valid changes; there are no registered stall outputs.

## Test plan
- Fetch only, if_addr=0x0040_0000, ack at L=2, port_rdata=0x2008_0005:
  - port_req high 2 cycles, then if_valid pulse with if_rdata=0x2008_0005.
  - PCWrite=0 and IF_ID_Bubble=1 until the valid cycle, then PCWrite=1.
- if_req and mem_req (load 0x1000_0010) rise together:
  - DATA is granted first, with Pipe_hold=1 and IF_ID_Bubble=0.
  - After mem_valid, FETCH is granted; if_valid arrives later.
- mem_req rises two cycles into a FETCH:
  - The fetch completes unaltered, then DATA is granted.
  - port_addr never changes mid-access.
- Store mem_we=1, addr=0x1000_0020, wdata=0xDEAD_BEEF, L=1:
  - port_we=1 with these values, mem_valid pulses, mem_rdata is unchanged.
- No ack for MAX_WAIT=15 cycles:
  - ERR is entered after cycle 15, bus_err=1, port_req=0, PCWrite=0, Pipe_hold=1.
  - A later port_ack is ignored; only reset clears.
  - Also check that an ack exactly at cycle 15 succeeds.
- reset low during DATA:
  - Outputs go to reset values immediately and no mem_valid is issued.
  - After release, a new fetch is granted normally.
